// File: rtl/key_scan.sv
// key_scan: 4-column x 3-row active-low keypad scanner with frame debounce.
// Drives one row low at a time, samples the synchronized columns at the end
// of each row dwell, assembles a 12-bit frame (bit = row*4 + col) and commits
// it to `key` once DB_FRAMES identical frames have been seen.
// Optional feature: define KEY_SCAN_GHOST_EN to reject frames with more than
// two pressed keys, where matrix ghosting can produce phantom keys.
module key_scan #(
   parameter int unsigned SCAN_DIV  = 1000,
   parameter int unsigned DB_FRAMES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  col_n,
   output logic [2:0]  row_n,
   output logic [11:0] key,
   output logic        key_vld
);

   localparam int unsigned DwW  = $clog2(SCAN_DIV);
   localparam int unsigned CntW = $clog2(DB_FRAMES);

   localparam logic [DwW-1:0]  DwLast  = DwW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DB_FRAMES - 1);

   typedef enum logic [1:0] {
      StRow0,
      StRow1,
      StRow2
   } row_state_e;

   // Column synchronizer
   logic [3:0]      col_meta_q;
   logic [3:0]      col_s_q;

   // Row scan
   row_state_e      state_q, state_d;
   logic [DwW-1:0]  dwell_q, dwell_d;
   logic [2:0]      row_n_q, row_n_d;
   logic            sample;

   // Frame assembly: rows 0 and 1 are held until row 2 completes the frame
   logic [7:0]      frm_q, frm_d;
   logic [3:0]      col_hit;
   logic [11:0]     frame;
   logic            frame_done;
   logic            frame_ok;

   // Debounce
   logic [11:0]     cand_q, cand_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_inc;
   logic [11:0]     key_q, key_d;
   logic            key_vld_q, key_vld_d;

   // Two-flop synchronizer on the asynchronous column inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_meta_q <= 4'b1111;
         col_s_q    <= 4'b1111;
      end else begin
         col_meta_q <= col_n;
         col_s_q    <= col_meta_q;
      end
   end

   // Row FSM next state: each row lasts SCAN_DIV cycles, sampled on the last
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q + DwW'(1);
      sample  = 1'b0;
      if (dwell_q == DwLast) begin
         dwell_d = '0;
         sample  = 1'b1;
         case (state_q)
            StRow0:  state_d = StRow1;
            StRow1:  state_d = StRow2;
            StRow2:  state_d = StRow0;
            default: state_d = StRow0;
         endcase
      end
   end

   // Row drive is registered from the next state so it changes with the FSM
   always_comb begin
      row_n_d = 3'b110;
      case (state_d)
         StRow0:  row_n_d = 3'b110;
         StRow1:  row_n_d = 3'b101;
         StRow2:  row_n_d = 3'b011;
         default: row_n_d = 3'b110;
      endcase
   end

   // Row FSM state, dwell counter and row drive registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRow0;
         dwell_q <= '0;
         row_n_q <= 3'b110;
      end else begin
         state_q <= state_d;
         dwell_q <= dwell_d;
         row_n_q <= row_n_d;
      end
   end

   // Capture the active row's closed columns into the partial frame
   always_comb begin
      col_hit    = ~col_s_q;
      frm_d      = frm_q;
      frame      = {col_hit, frm_q};
      frame_done = sample && (state_q == StRow2);
      if (sample) begin
         case (state_q)
            StRow0:  frm_d[3:0] = col_hit;
            StRow1:  frm_d[7:4] = col_hit;
            default: frm_d      = frm_q;
         endcase
      end
   end

   // Partial frame register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_q <= '0;
      end else begin
         frm_q <= frm_d;
      end
   end

`ifdef KEY_SCAN_GHOST_EN
   logic [3:0] ones;

   // Count pressed keys in the completed frame; more than two risks ghosting
   always_comb begin
      ones = '0;
      for (int i = 0; i < 12; i++) begin
         ones = ones + {3'b000, frame[i]};
      end
   end

   assign frame_ok = (ones <= 4'd2);
`else
   assign frame_ok = 1'b1;
`endif

   // Debounce update on the edge that completes each frame.
   // The frame that loads `cand` counts as the first identical frame, so the
   // commit happens on the frame that brings the count up to DB_FRAMES-1.
   always_comb begin
      cand_d    = cand_q;
      cnt_d     = cnt_q;
      key_d     = key_q;
      key_vld_d = 1'b0;
      cnt_inc   = (cnt_q == CntLast) ? cnt_q : (cnt_q + CntW'(1));
      if (frame_done) begin
         if (!frame_ok) begin
            cnt_d = '0;
         end else if (frame != cand_q) begin
            cand_d = frame;
            cnt_d  = '0;
         end else begin
            cnt_d = cnt_inc;
            if ((cnt_inc == CntLast) && (cand_q != key_q)) begin
               key_d     = cand_q;
               key_vld_d = 1'b1;
            end
         end
      end
   end

   // Debounce candidate, count and published key registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q    <= '0;
         cnt_q     <= '0;
         key_q     <= '0;
         key_vld_q <= 1'b0;
      end else begin
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         key_q     <= key_d;
         key_vld_q <= key_vld_d;
      end
   end

   assign row_n   = row_n_q;
   assign key     = key_q;
   assign key_vld = key_vld_q;

endmodule
